// File: rtl/reg_file_rd.sv
// Physical integer register file: registered read ports with a same-cycle write bypass
// and a registered flag for colliding writeback tags.
module reg_file_rd #(
    parameter int unsigned NUM_READS  = 6,
    parameter int unsigned NUM_WRITES = 4,
    parameter int unsigned TAG_W      = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_READS-1:0]        IN_rdValid,
    input  logic [NUM_READS*TAG_W-1:0]  IN_rdTag,
    output logic [NUM_READS*64-1:0]     OUT_rdData,
    input  logic [NUM_WRITES-1:0]       IN_wrValid,
    input  logic [NUM_WRITES*TAG_W-1:0] IN_wrTag,
    input  logic [NUM_WRITES*64-1:0]    IN_wrData,
    output logic                        OUT_busyWrConflict
);

    localparam int unsigned NUM_REGS = 2 ** TAG_W;

    logic [63:0] mem [NUM_REGS];
    logic [63:0] bypass [NUM_READS];
    logic [63:0] rd_q [NUM_READS];
    logic        conflict_d;
    logic        conflict_q;

    // Later loop iterations override earlier ones, so the highest write port wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned w = 0; w < NUM_WRITES; w++) begin
                if (IN_wrValid[w]) begin
                    mem[IN_wrTag[w*TAG_W +: TAG_W]] <= IN_wrData[w*64 +: 64];
                end
            end
        end
    end

    // Bypass uses the same priority order as storage so both always agree.
    always_comb begin
        for (int unsigned p = 0; p < NUM_READS; p++) begin
            bypass[p] = mem[IN_rdTag[p*TAG_W +: TAG_W]];
            for (int unsigned w = 0; w < NUM_WRITES; w++) begin
                if (IN_wrValid[w] &&
                    IN_wrTag[w*TAG_W +: TAG_W] == IN_rdTag[p*TAG_W +: TAG_W]) begin
                    bypass[p] = IN_wrData[w*64 +: 64];
                end
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WRITES; i++) begin
            for (int unsigned j = i + 1; j < NUM_WRITES; j++) begin
                if (IN_wrValid[i] && IN_wrValid[j] &&
                    IN_wrTag[i*TAG_W +: TAG_W] == IN_wrTag[j*TAG_W +: TAG_W]) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < NUM_READS; p++) begin
                rd_q[p] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_READS; p++) begin
                if (IN_rdValid[p]) begin
                    rd_q[p] <= bypass[p];
                end
            end
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_READS; p++) begin
            OUT_rdData[p*64 +: 64] = rd_q[p];
        end
    end

    assign OUT_busyWrConflict = conflict_q;

endmodule

// File: tb/tb_reg_file_rd.sv
// Self-checking bench for reg_file_rd: directed vector table, hold/reset sequences,
// and a random regression against a highest-index-wins reference memory.
module tb_reg_file_rd;

    localparam int NR = 6;
    localparam int NW = 4;
    localparam int TW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     rd_valid;
    logic [NR*TW-1:0]  rd_tag;
    logic [NR*64-1:0]  rd_data;
    logic [NW-1:0]     wr_valid;
    logic [NW*TW-1:0]  wr_tag;
    logic [NW*64-1:0]  wr_data;
    logic              conflict;

    always #5 clk = ~clk;

    reg_file_rd #(
        .NUM_READS (NR),
        .NUM_WRITES(NW),
        .TAG_W     (TW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IN_rdValid        (rd_valid),
        .IN_rdTag          (rd_tag),
        .OUT_rdData        (rd_data),
        .IN_wrValid        (wr_valid),
        .IN_wrTag          (wr_tag),
        .IN_wrData         (wr_data),
        .OUT_busyWrConflict(conflict)
    );

    typedef struct {
        logic [NW-1:0]          wv;
        logic [NW-1:0][TW-1:0]  wt;
        logic [NW-1:0][63:0]    wd;
        logic [NR-1:0]          rv;
        logic [NR-1:0][TW-1:0]  rt;
        logic [NR-1:0][63:0]    ex;
        logic                   exc;
    } vec_t;

    logic [63:0] ref_mem [64];
    logic [63:0] exp_rd [NR];
    logic        exp_conf;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [63:0] init_val(input int t);
        return 64'hA5A5_0000_0000_0000 | (64'(t) << 16) | 64'(t);
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v.wv = '0; v.wt = '0; v.wd = '0;
        v.rv = '0; v.rt = '0; v.ex = '0;
        v.exc = 1'b0;
        return v;
    endfunction

    function automatic logic [63:0] rd_out(input int p);
        return rd_data[p*64 +: 64];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rd_valid = '0; rd_tag = '0;
        wr_valid = '0; wr_tag = '0; wr_data = '0;
    endtask

    task automatic wr(input int p, input int tag, input logic [63:0] d);
        wr_valid[p] = 1'b1;
        wr_tag[p*TW +: TW] = TW'(tag);
        wr_data[p*64 +: 64] = d;
    endtask

    task automatic rd(input int p, input int tag);
        rd_valid[p] = 1'b1;
        rd_tag[p*TW +: TW] = TW'(tag);
    endtask

    // Reference model update for the current inputs, then advance one clock.
    task automatic step();
        logic [63:0] v;
        if (rst) begin
            for (int p = 0; p < NR; p++) exp_rd[p] = '0;
            exp_conf = 1'b0;
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (rd_valid[p]) begin
                    v = ref_mem[rd_tag[p*TW +: TW]];
                    for (int w = 0; w < NW; w++)
                        if (wr_valid[w] && wr_tag[w*TW +: TW] == rd_tag[p*TW +: TW])
                            v = wr_data[w*64 +: 64];
                    exp_rd[p] = v;
                end
            end
            exp_conf = 1'b0;
            for (int i = 0; i < NW; i++)
                for (int j = i + 1; j < NW; j++)
                    if (wr_valid[i] && wr_valid[j] && wr_tag[i*TW +: TW] == wr_tag[j*TW +: TW])
                        exp_conf = 1'b1;
            for (int w = 0; w < NW; w++)
                if (wr_valid[w]) ref_mem[wr_tag[w*TW +: TW]] = wr_data[w*64 +: 64];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        for (int p = 0; p < NR; p++)
            chk($sformatf("%s rd%0d", name, p), rd_out(p), exp_rd[p]);
        chk($sformatf("%s conflict", name), 64'(conflict), 64'(exp_conf));
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        rst = 1'b1;
        idle();
        for (int p = 0; p < NR; p++) exp_rd[p] = '0;
        exp_conf = 1'b0;

        // Reset with traffic present: outputs must be 0, writes dropped.
        rd(0, 3); rd(4, 3);
        wr(0, 3, 64'h1); wr(1, 3, 64'h2);
        step();
        step();
        for (int p = 0; p < NR; p++) chk($sformatf("reset rd%0d", p), rd_out(p), 64'h0);
        chk("reset conflict", 64'(conflict), 64'h0);
        rst = 1'b0;
        idle();

        for (int t = 0; t < 64; t += NW) begin
            idle();
            for (int w = 0; w < NW; w++) wr(w, t + w, init_val(t + w));
            step();
        end

        v = blank(); v.wv[0] = 1; v.wt[0] = 5; v.wd[0] = 64'h1111_2222_3333_4444;
        vecs.push_back(v);
        v = blank();
        vecs.push_back(v);
        v = blank(); v.rv[0] = 1; v.rt[0] = 5; v.ex[0] = 64'h1111_2222_3333_4444;
        vecs.push_back(v);
        v = blank(); v.wv[2] = 1; v.wt[2] = 9; v.wd[2] = 64'hAA;
        v.rv[0] = 1; v.rt[0] = 9; v.ex[0] = 64'hAA;
        v.rv[5] = 1; v.rt[5] = 9; v.ex[5] = 64'hAA;
        vecs.push_back(v);
        v = blank(); v.rv[1] = 1; v.rt[1] = 9; v.ex[1] = 64'hAA;
        vecs.push_back(v);
        v = blank(); v.wv[0] = 1; v.wt[0] = 3; v.wd[0] = 64'h1;
        v.wv[3] = 1; v.wt[3] = 3; v.wd[3] = 64'h2;
        v.rv[2] = 1; v.rt[2] = 3; v.ex[2] = 64'h2; v.exc = 1;
        vecs.push_back(v);
        v = blank(); v.rv[3] = 1; v.rt[3] = 3; v.ex[3] = 64'h2;
        vecs.push_back(v);
        v = blank();
        for (int p = 0; p < NR; p++) begin v.rv[p] = 1; v.rt[p] = 0; v.ex[p] = 64'hA5A5_0000_0000_0000; end
        vecs.push_back(v);
        v = blank(); v.wv[1] = 1; v.wt[1] = 63; v.wd[1] = 64'hDEAD;
        v.wv[2] = 1; v.wt[2] = 0; v.wd[2] = 64'hBEEF;
        for (int p = 0; p < 3; p++) begin v.rv[p] = 1; v.rt[p] = 63; v.ex[p] = 64'hDEAD; end
        for (int p = 3; p < NR; p++) begin v.rv[p] = 1; v.rt[p] = 0; v.ex[p] = 64'hBEEF; end
        vecs.push_back(v);
        v = blank();
        for (int w = 0; w < NW; w++) begin v.wv[w] = 1; v.wt[w] = 10; v.wd[w] = 64'(w + 1); end
        for (int p = 0; p < NR; p++) begin v.rv[p] = 1; v.rt[p] = 10; v.ex[p] = 64'h4; end
        v.exc = 1;
        vecs.push_back(v);
        v = blank(); v.wv[3] = 1; v.wt[3] = 11; v.wd[3] = 64'h5;
        v.wv[0] = 1; v.wt[0] = 11; v.wd[0] = 64'h6;
        v.rv[4] = 1; v.rt[4] = 11; v.ex[4] = 64'h5; v.exc = 1;
        vecs.push_back(v);
        v = blank();
        v.rv[0] = 1; v.rt[0] = 10; v.ex[0] = 64'h4;
        v.rv[1] = 1; v.rt[1] = 11; v.ex[1] = 64'h5;
        v.rv[2] = 1; v.rt[2] = 63; v.ex[2] = 64'hDEAD;
        v.rv[3] = 1; v.rt[3] = 5;  v.ex[3] = 64'h1111_2222_3333_4444;
        vecs.push_back(v);

        foreach (vecs[i]) begin
            idle();
            for (int w = 0; w < NW; w++) if (vecs[i].wv[w]) wr(w, int'(vecs[i].wt[w]), vecs[i].wd[w]);
            for (int p = 0; p < NR; p++) if (vecs[i].rv[p]) rd(p, int'(vecs[i].rt[p]));
            step();
            for (int p = 0; p < NR; p++)
                if (vecs[i].rv[p]) chk($sformatf("vec%0d rd%0d", i, p), rd_out(p), vecs[i].ex[p]);
            chk($sformatf("vec%0d conflict", i), 64'(conflict), 64'(vecs[i].exc));
        end

        // Hold on idle: port 0 keeps 0x77 while tag 7 is overwritten.
        idle(); wr(0, 7, 64'h77); step();
        idle(); rd(0, 7); step();
        chk("hold c1", rd_out(0), 64'h77);
        idle(); step();
        chk("hold c2", rd_out(0), 64'h77);
        idle(); wr(1, 7, 64'h88); step();
        chk("hold c3", rd_out(0), 64'h77);
        idle(); step();
        chk("hold c4", rd_out(0), 64'h77);
        idle(); step();
        chk("hold c5", rd_out(0), 64'h77);
        idle(); rd(0, 7); step();
        chk("hold reread", rd_out(0), 64'h88);

        // Reset mid-operation: in-flight read returns 0, write of tag 1 dropped.
        idle(); wr(0, 20, 64'h55); step();
        idle(); rst = 1'b1; rd(0, 20); wr(2, 1, 64'h99); step();
        for (int p = 0; p < NR; p++) chk($sformatf("midrst rd%0d", p), rd_out(p), 64'h0);
        chk("midrst conflict", 64'(conflict), 64'h0);
        rst = 1'b0;
        idle(); rd(0, 1); rd(1, 20); step();
        chk("postrst tag1", rd_out(0), 64'hA5A5_0000_0001_0001);
        chk("postrst tag20", rd_out(1), 64'h55);
        for (int p = 2; p < NR; p++) chk($sformatf("postrst idle rd%0d", p), rd_out(p), 64'h0);

        for (int c = 0; c < 400; c++) begin
            int mode;
            int same;
            idle();
            mode = int'($urandom_range(0, 3));
            same = int'($urandom_range(0, 63));
            for (int w = 0; w < NW; w++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    case (mode)
                        0: t = int'($urandom_range(0, 63));
                        1: t = ($urandom_range(0, 1) == 1) ? 63 : 0;
                        2: t = same;
                        default: t = int'($urandom_range(0, 3));
                    endcase
                    wr(w, t, {$urandom, $urandom});
                end
            end
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int t;
                    case (mode)
                        0: t = int'($urandom_range(0, 63));
                        1: t = ($urandom_range(0, 1) == 1) ? 63 : 0;
                        2: t = same;
                        default: t = int'($urandom_range(0, 3));
                    endcase
                    rd(p, t);
                end
            end
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
